// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_pkg;

  localparam int unsigned BYTE_W_DEF = 8;
  localparam int unsigned FRAME_OVH  = 2;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    PAYLOAD,
    TRAILER
  } state_e;

endpackage

// File: rtl/serial_receiver_if.sv
// Bit-stream input and parallel payload/status output of the serial receiver.
interface serial_receiver_if #(
  parameter int unsigned BYTE_W = 8
);

  logic              Din;
  logic              Din_Valid;
  logic [BYTE_W-1:0] Dout;
  logic              Dout_Valid;
  logic [BYTE_W-1:0] Length;
  logic              Busy;
  logic              Pkt_Done;
  logic              Pkt_Err;

  modport slave (
    input  Din, Din_Valid,
    output Dout, Dout_Valid, Length, Busy, Pkt_Done, Pkt_Err
  );

  modport master (
    output Din, Din_Valid,
    input  Dout, Dout_Valid, Length, Busy, Pkt_Done, Pkt_Err
  );

endinterface

// File: rtl/serial_deser.sv
// LSB-first byte assembler: shifts in qualified bits and pulses byte_done_o
// in the cycle after the last bit of a byte was sampled.
module serial_deser
  import serial_pkg::*;
#(
  parameter int unsigned BYTE_W = BYTE_W_DEF
) (
  input  logic              rClk,
  input  logic              Reset,
  input  logic              din_i,
  input  logic              din_valid_i,
  input  logic              clr_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_done_o
);

  localparam int unsigned     CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTE_W - 1);

  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  // A clear and a valid bit in the same cycle make that bit bit 0 of a new byte.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (clr_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end
    if (din_valid_i) begin
      shreg_d = {din_i, shreg_d[BYTE_W-1:1]};
      done_d  = (cnt_d == LAST);
      cnt_d   = done_d ? '0 : cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge rClk or posedge Reset) begin
    if (Reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign byte_o      = shreg_q;
  assign byte_done_o = done_q;

endmodule

// File: rtl/serial_receiver.sv
// Serial frame receiver: length byte, L payload bytes, trailer byte.
// Define SERIAL_RX_CHECKSUM_EN to check the trailer against the XOR of length and payload.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int unsigned BYTE_W  = BYTE_W_DEF,
  parameter int unsigned MIN_GAP = 1
) (
  input  logic            rClk,
  input  logic            Reset,
  serial_receiver_if.slave bus
);

  localparam int unsigned     GAP_W   = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] bcnt_q, bcnt_d;
  logic [BYTE_W-1:0] len_q, len_d;
  logic [BYTE_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
`ifdef SERIAL_RX_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_q, xor_d;
`endif

  logic              accept_c;
  logic              clr_c;
  logic              gap_ok_c;
  logic [BYTE_W-1:0] byte_w;
  logic              byte_done_w;

  serial_deser #(
    .BYTE_W (BYTE_W)
  ) u_deser (
    .rClk        (rClk),
    .Reset       (Reset),
    .din_i       (bus.Din),
    .din_valid_i (accept_c),
    .clr_i       (clr_c),
    .byte_o      (byte_w),
    .byte_done_o (byte_done_w)
  );

  assign gap_ok_c = (gap_q == GAP_MAX);

  // Consecutive idle-cycle counter; frame bits keep it at zero.
  always_comb begin
    gap_d = gap_q;
    if (bus.Din_Valid)           gap_d = '0;
    else if (gap_q != GAP_MAX)   gap_d = gap_q + GAP_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    len_d    = len_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    accept_c = 1'b0;
    clr_c    = 1'b0;
`ifdef SERIAL_RX_CHECKSUM_EN
    xor_d    = xor_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.Din_Valid && gap_ok_c) begin
          state_d  = LEN;
          accept_c = 1'b1;
        end
      end
      LEN: begin
        accept_c = bus.Din_Valid;
        if (byte_done_w) begin
          len_d   = byte_w;
          bcnt_d  = '0;
          state_d = (byte_w == '0) ? TRAILER : PAYLOAD;
`ifdef SERIAL_RX_CHECKSUM_EN
          xor_d   = byte_w;
`endif
        end
      end
      PAYLOAD: begin
        accept_c = bus.Din_Valid;
        if (byte_done_w) begin
          dout_d = byte_w;
          dv_d   = 1'b1;
          bcnt_d = bcnt_q + BYTE_W'(1);
          if (bcnt_d == len_q) state_d = TRAILER;
`ifdef SERIAL_RX_CHECKSUM_EN
          xor_d  = xor_q ^ byte_w;
`endif
        end
      end
      TRAILER: begin
        if (byte_done_w) begin
          state_d = IDLE;
          bcnt_d  = '0;
          clr_c   = 1'b1;
`ifdef SERIAL_RX_CHECKSUM_EN
          if (byte_w == xor_q) done_d = 1'b1;
          else                 err_d  = 1'b1;
`else
          done_d  = 1'b1;
`endif
          // With no required gap, a bit right after the trailer opens the next frame.
          if (MIN_GAP == 0 && bus.Din_Valid) begin
            state_d  = LEN;
            accept_c = 1'b1;
          end
        end else begin
          accept_c = bus.Din_Valid;
        end
      end
      default: state_d = IDLE;
    endcase

    // Missing bit inside a frame aborts it; delivered bytes stand.
    if (state_q != IDLE && state_d != IDLE && !bus.Din_Valid) begin
      state_d  = IDLE;
      bcnt_d   = '0;
      err_d    = 1'b1;
      clr_c    = 1'b1;
      accept_c = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge rClk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      len_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      gap_q   <= GAP_MAX;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      gap_q   <= gap_d;
    end
  end

`ifdef SERIAL_RX_CHECKSUM_EN
  always_ff @(posedge rClk or posedge Reset) begin
    if (Reset) xor_q <= '0;
    else       xor_q <= xor_d;
  end
`endif

  assign bus.Dout       = dout_q;
  assign bus.Dout_Valid = dv_q;
  assign bus.Length     = len_q;
  assign bus.Busy       = busy_q;
  assign bus.Pkt_Done   = done_q;
  assign bus.Pkt_Err    = err_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed-vector bench for serial_receiver (BYTE_W=8, MIN_GAP=1).
module tb_serial_receiver;
  import serial_pkg::*;

  logic rClk;
  logic Reset;

  serial_receiver_if #(.BYTE_W(8)) bus ();

  serial_receiver #(
    .BYTE_W  (8),
    .MIN_GAP (1)
  ) dut (
    .rClk  (rClk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial rClk = 1'b0;
  always #5 rClk = ~rClk;

  int tests = 0;
  int fails = 0;

  int         cyc = 0;
  logic [7:0] dv_val[$];
  int         dv_cyc[$];
  int         end_cyc[$];
  int         done_cnt, err_cnt, busy_cnt, done_cyc, err_cyc;
  int         both_cnt = 0;

  task automatic clr_mon();
    dv_val.delete(); dv_cyc.delete(); end_cyc.delete();
    done_cnt = 0; err_cnt = 0; busy_cnt = 0; done_cyc = -1; err_cyc = -1;
  endtask

  // Drive one cycle, then record what the DUT shows after the edge.
  task automatic tick(input logic v, input logic b);
    bus.Din = b; bus.Din_Valid = v;
    @(posedge rClk); #1;
    cyc++;
    if (bus.Dout_Valid === 1'b1) begin dv_val.push_back(bus.Dout); dv_cyc.push_back(cyc); end
    if (bus.Pkt_Done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (bus.Pkt_Err === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (bus.Busy === 1'b1) busy_cnt++;
    if (bus.Pkt_Done === 1'b1 && bus.Pkt_Err === 1'b1) both_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) tick(1'b1, b[k]);
    end_cyc.push_back(cyc);
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] trl);
    send_byte(len);
    if (len > 0) send_byte(p0);
    if (len > 1) send_byte(p1);
    if (len > 2) send_byte(p2);
    send_byte(trl);
  endtask

  task automatic test_reset();
    Reset = 1'b0; bus.Din = 1'b0; bus.Din_Valid = 1'b0;
    #1 Reset = 1'b1;
    @(posedge rClk); #1;
    tests++; if (bus.Dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h expected 00", bus.Dout); end
    tests++; if (bus.Dout_Valid !== 1'b0) begin fails++; $display("FAIL reset_dv: got %b expected 0", bus.Dout_Valid); end
    tests++; if (bus.Length !== 8'h00) begin fails++; $display("FAIL reset_len: got %h expected 00", bus.Length); end
    tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
    tests++; if (bus.Pkt_Done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.Pkt_Done); end
    tests++; if (bus.Pkt_Err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", bus.Pkt_Err); end
    #1 Reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    logic [7:0] chk;
    chk = 8'h03 ^ 8'hA5 ^ 8'h3C ^ 8'hFF;
    clr_mon();
    send_frame(8'd3, 8'hA5, 8'h3C, 8'hFF, chk);
    idle(2);
    tests++; if (bus.Length !== 8'd3) begin fails++; $display("FAIL good_length: got %0d expected 3", bus.Length); end
    tests++; if (dv_val.size() !== 3) begin fails++; $display("FAIL good_dv_count: got %0d expected 3", dv_val.size()); end
    if (dv_val.size() == 3) begin
      tests++; if (dv_val[0] !== 8'hA5) begin fails++; $display("FAIL good_byte0: got %h expected a5", dv_val[0]); end
      tests++; if (dv_val[1] !== 8'h3C) begin fails++; $display("FAIL good_byte1: got %h expected 3c", dv_val[1]); end
      tests++; if (dv_val[2] !== 8'hFF) begin fails++; $display("FAIL good_byte2: got %h expected ff", dv_val[2]); end
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (dv_cyc[i] !== end_cyc[i+1] + 1) begin
          fails++; $display("FAIL good_dv_latency%0d: got cycle %0d expected %0d", i, dv_cyc[i], end_cyc[i+1] + 1);
        end
      end
    end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL good_done_count: got %0d expected 1", done_cnt); end
    tests++; if (done_cyc !== end_cyc[4] + 1) begin fails++; $display("FAIL good_done_time: got %0d expected %0d", done_cyc, end_cyc[4] + 1); end
    tests++; if (err_cnt !== 0) begin fails++; $display("FAIL good_err_count: got %0d expected 0", err_cnt); end
    tests++; if (bus.Dout !== 8'hFF) begin fails++; $display("FAIL good_dout_hold: got %h expected ff", bus.Dout); end
  endtask

  task automatic test_bad_trailer();
    int exp_done, exp_err;
`ifdef SERIAL_RX_CHECKSUM_EN
    exp_done = 0; exp_err = 1;
`else
    exp_done = 1; exp_err = 0;
`endif
    clr_mon();
    send_frame(8'd3, 8'hA5, 8'h3C, 8'hFF, 8'h00);
    idle(2);
    tests++; if (dv_val.size() !== 3) begin fails++; $display("FAIL bad_dv_count: got %0d expected 3", dv_val.size()); end
    tests++; if (done_cnt !== exp_done) begin fails++; $display("FAIL bad_done: got %0d expected %0d", done_cnt, exp_done); end
    tests++; if (err_cnt !== exp_err) begin fails++; $display("FAIL bad_err: got %0d expected %0d", err_cnt, exp_err); end
  endtask

  task automatic test_zero_length();
    clr_mon();
    send_frame(8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(2);
    tests++; if (dv_val.size() !== 0) begin fails++; $display("FAIL zero_dv_count: got %0d expected 0", dv_val.size()); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL zero_done: got %0d expected 1", done_cnt); end
    tests++; if (done_cyc !== end_cyc[1] + 1) begin fails++; $display("FAIL zero_done_time: got %0d expected %0d", done_cyc, end_cyc[1] + 1); end
    tests++; if (busy_cnt !== FRAME_OVH * 8) begin fails++; $display("FAIL zero_busy_cycles: got %0d expected %0d", busy_cnt, FRAME_OVH * 8); end
    tests++; if (bus.Length !== 8'd0) begin fails++; $display("FAIL zero_length: got %0d expected 0", bus.Length); end
  endtask

  task automatic test_truncation();
    logic [7:0] b2;
    b2 = 8'h0F;
    clr_mon();
    send_byte(8'd2);
    send_byte(8'h5A);
    for (int k = 0; k < 4; k++) tick(1'b1, b2[k]);
    tick(1'b0, 1'b0);
    tests++; if (bus.Pkt_Err !== 1'b1) begin fails++; $display("FAIL trunc_err_strobe: got %b expected 1", bus.Pkt_Err); end
    tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL trunc_busy: got %b expected 0", bus.Busy); end
    idle(2);
    tests++; if (dv_val.size() !== 1) begin fails++; $display("FAIL trunc_dv_count: got %0d expected 1", dv_val.size()); end
    tests++; if (dv_val.size() != 0 && dv_val[0] !== 8'h5A) begin fails++; $display("FAIL trunc_byte: got %h expected 5a", dv_val[0]); end
    tests++; if (done_cnt !== 0 || err_cnt !== 1) begin fails++; $display("FAIL trunc_status: got done=%0d err=%0d expected done=0 err=1", done_cnt, err_cnt); end
    clr_mon();
    send_frame(8'd1, 8'hC3, 8'h00, 8'h00, 8'h01 ^ 8'hC3);
    idle(2);
    tests++; if (dv_val.size() !== 1 || dv_val[0] !== 8'hC3) begin fails++; $display("FAIL trunc_recover_byte: got n=%0d first=%h expected n=1 c3", dv_val.size(), dv_val[0]); end
    tests++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL trunc_recover_status: got done=%0d err=%0d expected done=1 err=0", done_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clr_mon();
    send_byte(8'd4);
    send_byte(8'h81);
    send_byte(8'h7E);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1);
    tests++; if (bus.Busy !== 1'b1 || bus.Dout !== 8'h7E || bus.Length !== 8'd4) begin
      fails++; $display("FAIL midrst_pre: got busy=%b dout=%h len=%0d expected busy=1 dout=7e len=4", bus.Busy, bus.Dout, bus.Length);
    end
    #3;
    Reset = 1'b1; bus.Din_Valid = 1'b0;
    #1;
    tests++; if (bus.Dout !== 8'h00) begin fails++; $display("FAIL midrst_dout: got %h expected 00", bus.Dout); end
    tests++; if (bus.Length !== 8'h00) begin fails++; $display("FAIL midrst_len: got %h expected 00", bus.Length); end
    tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", bus.Busy); end
    tests++; if (bus.Dout_Valid !== 1'b0 || bus.Pkt_Done !== 1'b0 || bus.Pkt_Err !== 1'b0) begin
      fails++; $display("FAIL midrst_strobes: got dv=%b done=%b err=%b expected 0 0 0", bus.Dout_Valid, bus.Pkt_Done, bus.Pkt_Err);
    end
    repeat (2) @(posedge rClk);
    #2 Reset = 1'b0;
    clr_mon();
    idle(1);
    send_frame(8'd2, 8'h11, 8'h22, 8'h00, 8'h02 ^ 8'h11 ^ 8'h22);
    idle(2);
    tests++; if (bus.Length !== 8'd2) begin fails++; $display("FAIL midrst_new_len: got %0d expected 2", bus.Length); end
    tests++; if (dv_val.size() !== 2 || dv_val[0] !== 8'h11 || dv_val[1] !== 8'h22) begin
      fails++; $display("FAIL midrst_new_bytes: got n=%0d %h %h expected n=2 11 22", dv_val.size(), dv_val[0], dv_val[1]);
    end
    tests++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL midrst_new_status: got done=%0d err=%0d expected 1 0", done_cnt, err_cnt); end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    send_frame(8'd1, 8'h3C, 8'h00, 8'h00, 8'h01 ^ 8'h3C);
    idle(1);
    send_frame(8'd1, 8'h44, 8'h00, 8'h00, 8'h01 ^ 8'h44);
    idle(2);
    tests++; if (done_cnt !== 2 || err_cnt !== 0) begin fails++; $display("FAIL b2b_gap1_status: got done=%0d err=%0d expected 2 0", done_cnt, err_cnt); end
    tests++; if (dv_val.size() !== 2 || dv_val[0] !== 8'h3C || dv_val[1] !== 8'h44) begin
      fails++; $display("FAIL b2b_gap1_bytes: got n=%0d %h %h expected n=2 3c 44", dv_val.size(), dv_val[0], dv_val[1]);
    end
    clr_mon();
    send_frame(8'd1, 8'h3C, 8'h00, 8'h00, 8'h01 ^ 8'h3C);
    send_frame(8'd1, 8'h44, 8'h00, 8'h00, 8'h01 ^ 8'h44);
    idle(3);
    tests++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL b2b_gap0_status: got done=%0d err=%0d expected 1 0", done_cnt, err_cnt); end
    tests++; if (dv_val.size() !== 1 || dv_val[0] !== 8'h3C) begin fails++; $display("FAIL b2b_gap0_bytes: got n=%0d first=%h expected n=1 3c", dv_val.size(), dv_val[0]); end
    tests++; if (busy_cnt !== (FRAME_OVH + 1) * 8) begin fails++; $display("FAIL b2b_gap0_busy: got %0d expected %0d", busy_cnt, (FRAME_OVH + 1) * 8); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_trailer();
    test_zero_length();
    test_truncation();
    test_reset_mid_frame();
    test_back_to_back();
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL done_err_exclusive: got %0d overlapping cycles expected 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
